mem_unit: RTL and testbench

- Responder for the core sequencer's FETCH and MEMORY stages.
- Takes the stage-active level for either stage and runs one bus transaction: an instruction fetch, a load or a store.
- Checks alignment, extracts and extends load data, and steers store lanes.
- Returns a held stage-done level plus the memory fault flags (mem_addr_fault, mem_access_fault, mem_fault_is_store) that the sequencer samples.

---
 rtl/mem_unit_if.sv | 21 ++
 rtl/mem_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_unit_if.sv
// rtl/mem_unit_if.sv - memory bus bundle between mem_unit (master) and the memory system (slave)
interface mem_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - FETCH/MEMORY stage responder: one bus transaction per stage activation
module mem_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        mem_en,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    output logic        fetch_done,
    output logic        mem_done,
    output logic [31:0] instr,
    output logic [31:0] load_data,
    output logic        mem_addr_fault,
    output logic        mem_access_fault,
    output logic        mem_fault_is_store,
    mem_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE, DRAIN} state_e;

    state_e      state_q;
    logic        op_fetch_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] cnt_q;

    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_store;
    logic        misaligned;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] load_ext;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic        orig_en;
    logic        timeout;
    logic        bus_end;

    // A fetch is treated as an aligned word read of pc
    always_comb begin
        req_addr  = fetch_en ? pc : addr;
        req_size  = fetch_en ? 2'b10 : size;
        req_store = ~fetch_en & is_store;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        wstrb_d = 4'b0000;
        wdata_d = 32'd0;
        if (req_store) begin
            case (req_size)
                2'b00: begin
                    wstrb_d = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                    wstrb_d = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_d = {2{store_data[15:0]}};
                end
                default: begin
                    wstrb_d = 4'b1111;
                    wdata_d = store_data;
                end
            endcase
        end
    end

    always_comb begin
        lb = bus.bus_rdata[{lane_q, 3'b000} +: 8];
        lh = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lb[7]}}, lb};
            2'b01:   load_ext = {{16{~uns_q & lh[15]}}, lh};
            default: load_ext = bus.bus_rdata;
        endcase
        orig_en = op_fetch_q ? fetch_en : mem_en;
        timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);
        bus_end = bus.bus_ack | bus.bus_err | timeout;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            op_fetch_q         <= 1'b0;
            lane_q             <= 2'b00;
            size_q             <= 2'b00;
            uns_q              <= 1'b0;
            cnt_q              <= 32'd0;
            fetch_done         <= 1'b0;
            mem_done           <= 1'b0;
            instr              <= 32'd0;
            load_data          <= 32'd0;
            mem_addr_fault     <= 1'b0;
            mem_access_fault   <= 1'b0;
            mem_fault_is_store <= 1'b0;
            bus.bus_req        <= 1'b0;
            bus.bus_we         <= 1'b0;
            bus.bus_addr       <= 32'd0;
            bus.bus_wstrb      <= 4'b0000;
            bus.bus_wdata      <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en || mem_en) begin
                        op_fetch_q         <= fetch_en;
                        lane_q             <= req_addr[1:0];
                        size_q             <= req_size;
                        uns_q              <= load_unsigned;
                        cnt_q              <= 32'd0;
                        mem_fault_is_store <= req_store;
                        if (misaligned) begin
                            state_q        <= DONE;
                            mem_addr_fault <= 1'b1;
                            fetch_done     <= fetch_en;
                            mem_done       <= ~fetch_en;
                        end else begin
                            state_q       <= BUS;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= req_store;
                            bus.bus_addr  <= {req_addr[31:2], 2'b00};
                            bus.bus_wstrb <= wstrb_d;
                            bus.bus_wdata <= wdata_d;
                        end
                    end
                end
                BUS, DRAIN: begin
                    if (bus_end) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_wstrb <= 4'b0000;
                        if (state_q == BUS && orig_en) begin
                            state_q          <= DONE;
                            fetch_done       <= op_fetch_q;
                            mem_done         <= ~op_fetch_q;
                            // err outranks ack; timeout only counts when neither arrived
                            mem_access_fault <= bus.bus_err | (~bus.bus_ack & timeout);
                            if (bus.bus_ack && !bus.bus_err) begin
                                if (op_fetch_q) instr <= bus.bus_rdata;
                                else if (!bus.bus_we) load_data <= load_ext;
                            end
                        end else begin
                            state_q            <= IDLE;
                            mem_fault_is_store <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                        if (!orig_en) state_q <= DRAIN;
                    end
                end
                DONE: begin
                    if (!orig_en) begin
                        state_q            <= IDLE;
                        fetch_done         <= 1'b0;
                        mem_done           <= 1'b0;
                        mem_addr_fault     <= 1'b0;
                        mem_access_fault   <= 1'b0;
                        mem_fault_is_store <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed self-checking bench for mem_unit
module tb_mem_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en, mem_en, is_store, load_unsigned;
    logic [31:0] pc, addr, store_data;
    logic [1:0]  size;
    logic        fetch_done, mem_done, mem_addr_fault, mem_access_fault, mem_fault_is_store;
    logic [31:0] instr, load_data;
    int          n_vec = 0;
    int          n_err = 0;

    mem_unit_if bus_if ();

    mem_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .mem_en(mem_en),
        .pc(pc), .addr(addr), .is_store(is_store), .size(size),
        .load_unsigned(load_unsigned), .store_data(store_data),
        .fetch_done(fetch_done), .mem_done(mem_done), .instr(instr), .load_data(load_data),
        .mem_addr_fault(mem_addr_fault), .mem_access_fault(mem_access_fault),
        .mem_fault_is_store(mem_fault_is_store), .bus(bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_mem(input logic st, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic uns);
        mem_en = 1'b1; is_store = st; size = sz; addr = a; store_data = d; load_unsigned = uns;
    endtask

    task automatic ack_with(input logic [31:0] rd, input logic err);
        bus_if.bus_ack = 1'b1; bus_if.bus_err = err; bus_if.bus_rdata = rd;
        tick();
        bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    endtask

    task automatic release_mem();
        mem_en = 1'b0;
        tick();
        check("mem_done_clear", {31'd0, mem_done}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; fetch_en = 1'b0; mem_en = 1'b0; is_store = 1'b0; load_unsigned = 1'b0;
        pc = 32'd0; addr = 32'd0; store_data = 32'd0; size = 2'b00;
        bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (3) tick();
        check("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
        check("rst_done", {30'd0, fetch_done, mem_done}, 32'd0);
        check("rst_flt", {29'd0, mem_addr_fault, mem_access_fault, mem_fault_is_store}, 32'd0);
        reset_n = 1'b1;
        tick();

        // fetch, ack two cycles after request
        fetch_en = 1'b1; pc = 32'h100;
        tick();
        check("f_req", {31'd0, bus_if.bus_req}, 32'd1);
        check("f_addr", bus_if.bus_addr, 32'h100);
        check("f_we_strb", {27'd0, bus_if.bus_we, bus_if.bus_wstrb}, 32'd0);
        tick();
        check("f_req_hold", {31'd0, bus_if.bus_req}, 32'd1);
        ack_with(32'hDEAD_BEEF, 1'b0);
        check("f_done", {30'd0, fetch_done, mem_done}, 32'h2);
        check("f_instr", instr, 32'hDEAD_BEEF);
        check("f_req_drop", {31'd0, bus_if.bus_req}, 32'd0);
        tick();
        check("f_done_hold", {31'd0, fetch_done}, 32'd1);
        fetch_en = 1'b0;
        tick();
        check("f_done_clear", {31'd0, fetch_done}, 32'd0);

        // byte loads, signed then unsigned
        start_mem(1'b0, 2'b00, 32'h203, 32'd0, 1'b0);
        tick();
        check("lb_addr", bus_if.bus_addr, 32'h200);
        check("lb_strb", {28'd0, bus_if.bus_wstrb}, 32'd0);
        ack_with(32'h80FF_FF00, 1'b0);
        check("lb_signed", load_data, 32'hFFFF_FF80);
        check("lb_done", {31'd0, mem_done}, 32'd1);
        release_mem();
        start_mem(1'b0, 2'b00, 32'h203, 32'd0, 1'b1);
        tick();
        ack_with(32'h80FF_FF00, 1'b0);
        check("lbu", load_data, 32'h0000_0080);
        release_mem();
        start_mem(1'b0, 2'b01, 32'h202, 32'd0, 1'b0);
        tick();
        ack_with(32'h80FF_FF00, 1'b0);
        check("lh_signed", load_data, 32'hFFFF_80FF);
        release_mem();

        // half and byte stores
        start_mem(1'b1, 2'b01, 32'h302, 32'h1234_ABCD, 1'b0);
        tick();
        check("sh_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
        check("sh_strb", {28'd0, bus_if.bus_wstrb}, 32'hC);
        check("sh_we", {31'd0, bus_if.bus_we}, 32'd1);
        check("sh_addr", bus_if.bus_addr, 32'h300);
        ack_with(32'd0, 1'b0);
        check("sh_done", {31'd0, mem_done}, 32'd1);
        check("sh_nofault", {30'd0, mem_addr_fault, mem_access_fault}, 32'd0);
        release_mem();
        start_mem(1'b1, 2'b00, 32'h301, 32'h0000_00AB, 1'b0);
        tick();
        check("sb_wdata", bus_if.bus_wdata, 32'hABAB_ABAB);
        check("sb_strb", {28'd0, bus_if.bus_wstrb}, 32'h2);
        ack_with(32'd0, 1'b0);
        release_mem();

        // misaligned store word, misaligned fetch, reserved size
        start_mem(1'b1, 2'b10, 32'h401, 32'h5555_5555, 1'b0);
        tick();
        check("sw_mis_req", {31'd0, bus_if.bus_req}, 32'd0);
        check("sw_mis_flags", {28'd0, mem_done, mem_addr_fault, mem_access_fault, mem_fault_is_store}, 32'hD);
        release_mem();
        check("sw_mis_clr", {29'd0, mem_addr_fault, mem_access_fault, mem_fault_is_store}, 32'd0);
        fetch_en = 1'b1; pc = 32'h102;
        tick();
        check("f_mis_req", {31'd0, bus_if.bus_req}, 32'd0);
        check("f_mis_flags", {28'd0, fetch_done, mem_done, mem_addr_fault, mem_fault_is_store}, 32'hA);
        fetch_en = 1'b0;
        tick();
        start_mem(1'b0, 2'b11, 32'h400, 32'd0, 1'b0);
        tick();
        check("rsv_flags", {29'd0, bus_if.bus_req, mem_done, mem_addr_fault}, 32'h3);
        release_mem();

        // timeout after four wait cycles
        start_mem(1'b0, 2'b10, 32'h500, 32'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_req_hold", {31'd0, bus_if.bus_req}, 32'd1);
        end
        tick();
        check("to_req_drop", {31'd0, bus_if.bus_req}, 32'd0);
        check("to_flags", {29'd0, mem_done, mem_addr_fault, mem_access_fault}, 32'h5);
        release_mem();

        // err together with ack: access fault, load_data untouched
        start_mem(1'b0, 2'b10, 32'h600, 32'd0, 1'b0);
        tick();
        ack_with(32'h1234_5678, 1'b1);
        check("err_flags", {30'd0, mem_done, mem_access_fault}, 32'h3);
        check("err_ldata", load_data, 32'hFFFF_80FF);
        release_mem();

        // reset in the middle of a transfer
        start_mem(1'b0, 2'b10, 32'h700, 32'd0, 1'b0);
        tick();
        check("rb_req", {31'd0, bus_if.bus_req}, 32'd1);
        reset_n = 1'b0;
        tick();
        check("rb_req_clr", {31'd0, bus_if.bus_req}, 32'd0);
        check("rb_ldata", load_data, 32'd0);
        check("rb_instr", instr, 32'd0);
        check("rb_addr", bus_if.bus_addr, 32'd0);
        reset_n = 1'b1; mem_en = 1'b0;
        tick();

        // enable dropped mid-transfer drains without done
        start_mem(1'b1, 2'b10, 32'h800, 32'hCAFE_F00D, 1'b0);
        tick();
        check("dr_wdata", bus_if.bus_wdata, 32'hCAFE_F00D);
        mem_en = 1'b0;
        tick();
        check("dr_req_hold", {31'd0, bus_if.bus_req}, 32'd1);
        check("dr_no_done", {31'd0, mem_done}, 32'd0);
        ack_with(32'd0, 1'b0);
        check("dr_req_drop", {31'd0, bus_if.bus_req}, 32'd0);
        check("dr_no_done2", {31'd0, mem_done}, 32'd0);
        tick();
        check("dr_no_done3", {30'd0, fetch_done, mem_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
